// File: rtl/tpm_partner.sv
// One partner of a tree parity machine key exchange. The weights are seeded from a
// private LFSR and the hidden sums are accumulated serially, one weight per cycle.
module tpm_partner #(
    parameter int K  = 2,
    parameter int N  = 3,
    parameter int L  = 3,
    parameter int WB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [K*N-1:0]    feed,
    input  logic              out_other,
    input  logic [2:0]        ctrl,
    input  logic [2:0]        partner_no,
    output logic              out,
    output logic [K-1:0]      deltas,
    output logic              dirty,
    output logic [K*N*WB-1:0] weights
);
    localparam int NW = K * N;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam int AW = $clog2(N * L + 1) + 1;

    localparam logic [2:0] CMD_INIT    = 3'b001;
    localparam logic [2:0] CMD_COMPUTE = 3'b010;
    localparam logic [2:0] CMD_LEARN   = 3'b100;

    localparam logic [9:0]           LFSR_SEED_HI = 10'b1010110011;
    localparam logic [7:0]           MOD_BASE     = 8'(2 * L + 1);
    localparam logic signed [WB-1:0] W_ZERO       = WB'(0);
    localparam logic signed [WB-1:0] W_ONE        = WB'(1);
    localparam logic signed [WB-1:0] W_MAX        = WB'(L);
    localparam logic signed [WB-1:0] W_MIN        = -W_MAX;
    localparam logic signed [AW-1:0] ACC_ZERO     = AW'(0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_INIT    = 2'b01,
        ST_COMPUTE = 2'b10
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [2:0]           last_cmd_r;
    logic [CW-1:0]        cnt_r;
    logic [12:0]          lfsr_r;
    logic signed [WB-1:0] w_r [NW];
    logic signed [AW-1:0] acc_r [K];
    logic [K-1:0]         deltas_r;
    logic                 out_r;

    logic                 busy_s;
    logic                 accept_s;
    logic                 learn_s;
    logic                 cnt_last_s;
    logic signed [WB-1:0] w_init_s;
    logic signed [WB-1:0] w_learn_s [NW];
    logic signed [AW-1:0] term_s [NW];
    logic signed [AW-1:0] acc_nxt_s [K];
    logic [K-1:0]         sigma_nxt_s;

    function automatic logic [12:0] lfsr_step(input logic [12:0] l);
        return {l[11:0], l[12] ^ l[3] ^ l[2] ^ l[0]};
    endfunction

    function automatic logic signed [WB-1:0] rand_weight(input logic [7:0] v);
        logic [7:0] m;
        m = v % MOD_BASE;
        return $signed(WB'(m)) - W_MAX;
    endfunction

    function automatic logic signed [WB-1:0] clip_step(input logic signed [WB-1:0] w,
                                                       input logic up);
        logic signed [WB-1:0] r;
        if (up) begin
            r = (w >= W_MAX) ? W_MAX : w + W_ONE;
        end else begin
            r = (w <= W_MIN) ? W_MIN : w - W_ONE;
        end
        return r;
    endfunction

    // Product of the +/-1 hidden signs: +1 exactly when the count of -1 units is even.
    function automatic logic tau_of(input logic [K-1:0] s);
        return ~(^(~s));
    endfunction

    assign busy_s     = (state_r != ST_IDLE);
    assign accept_s   = !busy_s && (ctrl != last_cmd_r);
    assign learn_s    = accept_s && (ctrl == CMD_LEARN);
    assign cnt_last_s = (cnt_r == CW'(NW - 1));
    assign dirty      = busy_s || (ctrl != last_cmd_r);
    assign w_init_s   = rand_weight(lfsr_r[7:0]);
    assign out        = out_r;
    assign deltas     = deltas_r;

    // Next-state logic for the multi-cycle init and compute sequences.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (ctrl == CMD_INIT)) begin
                    state_nxt_s = ST_INIT;
                end else if (accept_s && (ctrl == CMD_COMPUTE)) begin
                    state_nxt_s = ST_COMPUTE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_INIT, ST_COMPUTE: begin
                if (cnt_last_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // One signed product per cycle; only the term selected by the counter is non-zero.
    always_comb begin
        sigma_nxt_s = {K{1'b0}};
        for (int i = 0; i < NW; i++) begin
            term_s[i] = (cnt_r == CW'(i)) ? (feed[i] ? AW'(w_r[i]) : -AW'(w_r[i])) : ACC_ZERO;
        end
        for (int k = 0; k < K; k++) begin
            acc_nxt_s[k] = acc_r[k];
            for (int j = 0; j < N; j++) begin
                acc_nxt_s[k] = acc_nxt_s[k] + term_s[k * N + j];
            end
            sigma_nxt_s[k] = (acc_nxt_s[k] > ACC_ZERO);
        end
    end

    // Hebbian update: only when both partners agree, and only units that agreed with tau.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            w_learn_s[i] = w_r[i];
            if ((out_other == out_r) && (deltas_r[i / N] == out_r)) begin
                w_learn_s[i] = clip_step(w_r[i], feed[i] == out_r);
            end else begin
                w_learn_s[i] = w_r[i];
            end
        end
    end

    // Debug view of the weight array, w_i at bits [i*WB +: WB].
    always_comb begin
        weights = {(K * N * WB){1'b0}};
        for (int i = 0; i < NW; i++) begin
            weights[i * WB +: WB] = w_r[i];
        end
    end

    // Sequence state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command handshake and the weight-index counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_cmd_r <= 3'b000;
            cnt_r      <= CW'(0);
        end else if (accept_s) begin
            last_cmd_r <= ctrl;
            cnt_r      <= CW'(0);
        end else if (busy_s) begin
            cnt_r <= cnt_last_s ? CW'(0) : cnt_r + CW'(1);
        end
    end

    // Weight storage and LFSR; the seed embeds partner_no so each partner differs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= {LFSR_SEED_HI, partner_no};
            for (int i = 0; i < NW; i++) begin
                w_r[i] <= W_ZERO;
            end
        end else if (state_r == ST_INIT) begin
            lfsr_r <= lfsr_step(lfsr_r);
            for (int i = 0; i < NW; i++) begin
                if (cnt_r == CW'(i)) begin
                    w_r[i] <= w_init_s;
                end
            end
        end else if (learn_s) begin
            for (int i = 0; i < NW; i++) begin
                w_r[i] <= w_learn_s[i];
            end
        end
    end

    // Accumulators and the registered hidden signs / output, updated together at the end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < K; k++) begin
                acc_r[k] <= ACC_ZERO;
            end
            deltas_r <= {K{1'b0}};
            out_r    <= 1'b0;
        end else if (accept_s) begin
            for (int k = 0; k < K; k++) begin
                acc_r[k] <= ACC_ZERO;
            end
        end else if (state_r == ST_COMPUTE) begin
            for (int k = 0; k < K; k++) begin
                acc_r[k] <= acc_nxt_s[k];
            end
            if (cnt_last_s) begin
                deltas_r <= sigma_nxt_s;
                out_r    <= tau_of(sigma_nxt_s);
            end
        end
    end
endmodule

// File: tb/tb_tpm_partner.sv
// Directed bench for tpm_partner: reset, init from hand-stepped LFSR, compute, learn
// with saturation, and reset aborting a compute.
module tb_tpm_partner;
    logic        clk;
    logic        rst;
    logic [5:0]  feed;
    logic        out_other;
    logic [2:0]  ctrl;
    logic [2:0]  partner_no;
    logic        out;
    logic [1:0]  deltas;
    logic        dirty;
    logic [23:0] weights;

    int checks;
    int errors;
    int n;
    logic [23:0] w_p2;
    logic [23:0] exp_learn [3];

    tpm_partner dut (
        .clk        (clk),
        .rst        (rst),
        .feed       (feed),
        .out_other  (out_other),
        .ctrl       (ctrl),
        .partner_no (partner_no),
        .out        (out),
        .deltas     (deltas),
        .dirty      (dirty),
        .weights    (weights)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] pk(input int a0, input int a1, input int a2,
                                       input int a3, input int a4, input int a5);
        return {4'(a5), 4'(a4), 4'(a3), 4'(a2), 4'(a1), 4'(a0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic range_check(input string tag);
        logic signed [3:0] w;
        for (int i = 0; i < 6; i++) begin
            w = weights[i * 4 +: 4];
            check($sformatf("%s_w%0d_range", tag, i), 32'((w >= -4'sd3) && (w <= 4'sd3)), 32'd1);
        end
    endtask

    // Waits for the accept edge, then counts sampled cycles with dirty high (bounded).
    task automatic wait_done(output int cycles);
        @(posedge clk);
        #1;
        cycles = 0;
        while (dirty && (cycles < 50)) begin
            cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_cmd(input logic [2:0] c, output int cycles);
        ctrl = c;
        wait_done(cycles);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        w_p2 = pk(-3, 0, -3, -2, 3, -1);
        exp_learn[0] = pk(-3, 0, -3, -3, 3, -2);
        exp_learn[1] = pk(-3, 0, -3, -3, 3, -3);
        exp_learn[2] = pk(-3, 0, -3, -3, 3, -3);

        rst = 1'b0;
        partner_no = 3'b010;
        ctrl = 3'b000;
        feed = 6'b000000;
        out_other = 1'b0;
        #12;
        check("rst_out", 32'(out), 32'd0);
        check("rst_deltas", 32'(deltas), 32'd0);
        check("rst_weights", 32'(weights), 32'd0);
        check("rst_dirty", 32'(dirty), 32'd0);
        ctrl = 3'b010;
        #1;
        check("dirty_on_cmd", 32'(dirty), 32'd1);

        // Compute with all-zero weights: both sums 0 -> sigma=-1,-1 -> tau=+1.
        feed = 6'b110100;
        rst = 1'b1;
        wait_done(n);
        check("zero_compute_cycles", 32'(n), 32'd6);
        check("zero_compute_out", 32'(out), 32'd1);
        check("zero_compute_deltas", 32'(deltas), 32'd0);

        run_cmd(3'b001, n);
        check("init_cycles", 32'(n), 32'd6);
        check("init_weights_p2", 32'(weights), 32'(w_p2));
        range_check("init_p2");

        // All +1 inputs: sums -6 and 0 -> both -1 -> tau=+1.
        feed = 6'b111111;
        run_cmd(3'b000, n);
        run_cmd(3'b010, n);
        check("comp1_cycles", 32'(n), 32'd6);
        check("comp1_out", 32'(out), 32'd1);
        check("comp1_deltas", 32'(deltas), 32'd0);

        out_other = 1'b0;
        run_cmd(3'b100, n);
        check("learn_mismatch_cycles", 32'(n), 32'd0);
        check("learn_mismatch_weights", 32'(weights), 32'(w_p2));

        // Unit0 sum +6, unit1 negative -> tau=-1; unit1 learns toward -x and saturates.
        feed = 6'b101010;
        for (int r = 0; r < 3; r++) begin
            run_cmd(3'b000, n);
            run_cmd(3'b010, n);
            check($sformatf("learn_loop%0d_comp_cycles", r), 32'(n), 32'd6);
            check($sformatf("learn_loop%0d_out", r), 32'(out), 32'd0);
            check($sformatf("learn_loop%0d_deltas", r), 32'(deltas), 32'd1);
            run_cmd(3'b100, n);
            check($sformatf("learn_loop%0d_cycles", r), 32'(n), 32'd0);
            check($sformatf("learn_loop%0d_weights", r), 32'(weights), 32'(exp_learn[r]));
        end
        range_check("learned");

        feed = 6'b111111;
        run_cmd(3'b000, n);
        run_cmd(3'b010, n);
        check("comp2_out", 32'(out), 32'd1);
        check("comp2_deltas", 32'(deltas), 32'd0);

        // Abort a compute with reset in its third cycle.
        partner_no = 3'b001;
        run_cmd(3'b000, n);
        ctrl = 3'b010;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("midcomp_dirty", 32'(dirty), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_weights", 32'(weights), 32'd0);
        check("abort_out", 32'(out), 32'd0);
        check("abort_deltas", 32'(deltas), 32'd0);
        ctrl = 3'b000;
        #1;
        check("abort_dirty", 32'(dirty), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        run_cmd(3'b001, n);
        check("init_p1_cycles", 32'(n), 32'd6);
        check("init_p1_w0", 32'(weights[3:0]), 32'h3);
        check("init_p1_differs", 32'(weights != w_p2), 32'd1);
        range_check("init_p1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
